instr_mem_pipe: RTL and testbench

INSTR_MEM_PIPE -- requirements
Module: instr_mem_pipe

---
 rtl/instr_mem_pipe.sv | 136 +++++++++++++
 tb/tb_instr_mem_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_pipe.sv
// Instruction memory: one registered read stage (S1) feeding an in-order response FIFO.
// The program-load write port is read-first with respect to same-cycle fetches.
module instr_mem_pipe #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned RSP_DEPTH = 3,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        flush
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(RSP_DEPTH);
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } rsp_t;

    // Contents survive reset; only the declaration establishes the fill word.
    logic [31:0] r_mem [DEPTH] = '{default: NOP_WORD};

    logic          r_s1_valid;
    rsp_t          r_s1;
    rsp_t          r_fifo [RSP_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [AW-1:0] w_rd_idx;
    logic          w_rd_err;
    logic [AW-1:0] w_wr_idx;
    logic          w_wr_ok;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_occ;
    logic [CW-1:0] w_count_nxt;
    rsp_t          w_head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_rd_idx = req_addr[AW+1:2];
    assign w_rd_err = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
    assign w_wr_idx = wr_addr[AW+1:2];
    assign w_wr_ok  = (wr_addr[1:0] == 2'b00) && (wr_addr[31:AW+2] == '0);

    // Ready depends only on state so there is no path from rsp_ready/req_valid.
    assign w_occ     = {1'b0, r_count} + {{CW{1'b0}}, r_s1_valid};
    assign req_ready = !rst && (w_occ < (CW+1)'(RSP_DEPTH));
    assign w_accept  = req_valid && req_ready;

    assign w_push = r_s1_valid;
    assign w_pop  = rsp_valid && rsp_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && w_wr_ok) begin
            r_mem[w_wr_idx] <= wr_data;
        end
    end

    // Read stage: data is sampled before this edge's write lands (read-first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1.instr <= w_rd_err ? NOP_WORD : r_mem[w_rd_idx];
                r_s1.addr  <= req_addr;
                r_s1.err   <= w_rd_err;
            end
        end
    end

    // S1 always has a slot reserved by the ready rule, so a push never overflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_fifo[r_wr_ptr] <= r_s1;
        end
    end

    assign w_head    = r_fifo[r_rd_ptr];
    assign rsp_valid = !rst && (r_count != '0);
    assign rsp_instr = rsp_valid ? w_head.instr : '0;
    assign rsp_addr  = rsp_valid ? w_head.addr : '0;
    assign rsp_err   = rsp_valid ? w_head.err : 1'b0;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed bench for instr_mem_pipe with default parameters (DEPTH=256, RSP_DEPTH=3).
module tb_instr_mem_pipe;
    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        flush;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] prog [3] = '{32'h0050_0093, 32'h0030_8113, 32'h0021_01B3};
    localparam logic [31:0] NOP = 32'h0000_0013;

    instr_mem_pipe dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) step();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_checks++; if (rsp_instr !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_instr: got %h want 0", rsp_instr); end
        n_checks++; if (rsp_addr !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_addr: got %h want 0", rsp_addr); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
        step();
    endtask

    task automatic test_load_fetch();
        logic [31:0] exp_w [4];
        exp_w = '{prog[0], prog[1], prog[2], NOP};
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_addr = 32'(4 * i);
            wr_data = prog[i];
            step();
        end
        wr_en = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                req_valid = 1'b1;
                req_addr  = 32'(4 * i);
                n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready[%0d]: got %b want 1", i, req_ready); end
            end else begin
                req_valid = 1'b0;
            end
            if (i >= 2 && i < 6) begin
                n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid[%0d]: got %b want 1", i, rsp_valid); end
                n_checks++; if (rsp_instr !== exp_w[i-2]) begin n_fail++; $display("FAIL load_instr[%0d]: got %h want %h", i, rsp_instr, exp_w[i-2]); end
                n_checks++; if (rsp_addr !== 32'(4 * (i - 2))) begin n_fail++; $display("FAIL load_addr[%0d]: got %h want %h", i, rsp_addr, 32'(4 * (i - 2))); end
                n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL load_err[%0d]: got %b want 0", i, rsp_err); end
            end else begin
                n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL load_idle[%0d]: got %b want 0", i, rsp_valid); end
            end
            step();
        end
    endtask

    task automatic test_errors();
        wr_en = 1'b1; wr_addr = 32'h400; wr_data = 32'hDEAD_BEEF;
        step();
        wr_addr = 32'h1; wr_data = 32'h0BAD_F00D;
        step();
        wr_en = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h2;
        step();
        req_valid = 1'b0;
        step();
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mis_valid: got %b want 1", rsp_valid); end
        n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %b want 1", rsp_err); end
        n_checks++; if (rsp_instr !== NOP) begin n_fail++; $display("FAIL mis_instr: got %h want %h", rsp_instr, NOP); end
        n_checks++; if (rsp_addr !== 32'h2) begin n_fail++; $display("FAIL mis_addr: got %h want 2", rsp_addr); end
        req_valid = 1'b1; req_addr = 32'h400;
        step();
        req_valid = 1'b0;
        step();
        n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", rsp_err); end
        n_checks++; if (rsp_instr !== NOP) begin n_fail++; $display("FAIL oor_instr: got %h want %h", rsp_instr, NOP); end
        n_checks++; if (rsp_addr !== 32'h400) begin n_fail++; $display("FAIL oor_addr: got %h want 400", rsp_addr); end
        step();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL err_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        logic exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int   idx = 0;
        logic got_rdy;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = (idx < 5);
            req_addr  = 32'(4 * idx);
            got_rdy   = req_ready;
            n_checks++; if (got_rdy !== exp_rdy[i]) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want %b", i, got_rdy, exp_rdy[i]); end
            step();
            if (got_rdy) idx++;
        end
        req_valid = 1'b0;
        n_checks++; if (idx != 3) begin n_fail++; $display("FAIL bp_accepted: got %0d want 3", idx); end
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 32'h0 || rsp_instr !== prog[0]) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b a=%h d=%h want v=1 a=0 d=%h", i, rsp_valid, rsp_addr, rsp_instr, prog[0]);
            end
            step();
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 32'(4 * i) || rsp_instr !== prog[i]) begin
                n_fail++; $display("FAIL bp_drain[%0d]: got v=%b a=%h d=%h want v=1 a=%h d=%h", i, rsp_valid, rsp_addr, rsp_instr, 32'(4 * i), prog[i]);
            end
            step();
        end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", rsp_valid); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", req_ready); end
    endtask

    task automatic test_read_first();
        rsp_ready = 1'b1;
        wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'hAAAA_0013;
        req_valid = 1'b1; req_addr = 32'h10;
        step();
        wr_en = 1'b0;
        step();
        req_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_instr !== NOP) begin n_fail++; $display("FAIL rf_old: got v=%b d=%h want v=1 d=%h", rsp_valid, rsp_instr, NOP); end
        step();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'hAAAA_0013) begin n_fail++; $display("FAIL rf_new: got v=%b d=%h want v=1 d=aaaa0013", rsp_valid, rsp_instr); end
        n_checks++; if (rsp_addr !== 32'h10) begin n_fail++; $display("FAIL rf_addr: got %h want 10", rsp_addr); end
        step();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rf_empty: got %b want 0", rsp_valid); end
    endtask

    task automatic test_flush();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = 32'(4 * i);
            step();
        end
        req_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL fl_pre_valid: got %b want 1", rsp_valid); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL fl_pre_ready: got %b want 0", req_ready); end
        flush = 1'b1; rsp_ready = 1'b1;
        step();
        flush = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b want 0", rsp_valid); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL fl_ready: got %b want 1", req_ready); end
        req_valid = 1'b1; req_addr = 32'hC; flush = 1'b1;
        step();
        req_valid = 1'b0; flush = 1'b0;
        step();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fl_accept_dropped: got %b want 0", rsp_valid); end
        req_valid = 1'b1; req_addr = 32'h10;
        step();
        req_valid = 1'b0;
        step();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 32'h10 || rsp_instr !== 32'hAAAA_0013) begin
            n_fail++; $display("FAIL fl_new: got v=%b a=%h d=%h want v=1 a=10 d=aaaa0013", rsp_valid, rsp_addr, rsp_instr);
        end
        step();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fl_only_new: got %b want 0", rsp_valid); end
    endtask

    task automatic test_reset_midstream();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = 32'(4 * i);
            step();
        end
        req_valid = 1'b0;
        step();
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rm_full: got %b want 1", rsp_valid); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_instr !== 32'h0 || rsp_addr !== 32'h0 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL rm_zero: got v=%b d=%h a=%h e=%b want all 0", rsp_valid, rsp_instr, rsp_addr, rsp_err);
        end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready_low: got %b want 0", req_ready); end
        step();
        rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_high: got %b want 1", req_ready); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_stale[%0d]: got %b want 0", i, rsp_valid); end
        end
        for (int i = 0; i < 5; i++) begin
            req_valid = (i < 3);
            req_addr  = 32'(4 * i);
            if (i >= 2) begin
                n_checks++; if (rsp_valid !== 1'b1 || rsp_instr !== prog[i-2]) begin
                    n_fail++; $display("FAIL rm_mem[%0d]: got v=%b d=%h want v=1 d=%h", i - 2, rsp_valid, rsp_instr, prog[i-2]);
                end
            end
            step();
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; flush = 1'b0;
        test_reset();
        test_load_fetch();
        test_errors();
        test_backpressure();
        test_read_first();
        test_flush();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
